// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared state, opcode, func3 and select encodings for the RV32I multicycle controller
package multicycle_controller_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_READ, MEM_WB,
    MEM_WRITE, BRANCH, JAL, JALR_ADR, JALR_JMP, LUI, TRAP
  } state_t;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RF  = 2'b10;
  localparam logic [1:0] ALU_IF  = 2'b11;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RS1   = 2'b10;
  localparam logic [1:0] SB_RS2  = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    return op == OP_SW  ? IMM_S :
           op == OP_BR  ? IMM_B :
           op == OP_JAL ? IMM_J :
           op == OP_LUI ? IMM_U : IMM_I;
  endfunction
endpackage

// File: rtl/mc_branch_eval.sv
// mc_branch_eval: branch-taken decision from func3 and ALU flags
//   in  func3, zero (ALU result == 0), neg (signed less-than)
//   out taken (unsupported func3 is never taken)
module mc_branch_eval
  import multicycle_controller_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       taken
);
  always_comb
    taken = func3 == F3_BEQ ? zero :
            func3 == F3_BNE ? !zero :
            func3 == F3_BLT ? neg :
            func3 == F3_BGE ? !neg : 1'b0;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing a shared-memory single-ALU RV32I multicycle datapath
//   in  clk, rst_n (sync, active-low), op/func3 from IR, zero/neg ALU flags, mem_ready handshake
//   out mem_req/memWrite/adrSrc memory control, irWrite/pcWrite/regWrite enables,
//       ALUSrcA/ALUSrcB/ALUOp/resultSrc/immSrc selects, sticky illegal, instret retire count
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic             zero,
  input  logic             neg,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memWrite,
  output logic             adrSrc,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             regWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       resultSrc,
  output logic [2:0]       immSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);
  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             taken, retire;
  mc_branch_eval u_branch_eval (
    .func3(func3),
    .zero (zero),
    .neg  (neg),
    .taken(taken)
  );
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    memWrite  = 1'b0;
    adrSrc    = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    ALUSrcA   = SA_PC;
    ALUSrcB   = SB_RS2;
    ALUOp     = ALU_ADD;
    resultSrc = RES_ALUOUT;
    immSrc    = imm_sel(op);
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SB_FOUR;
        resultSrc = RES_ALU;
        irWrite   = mem_ready;
        pcWrite   = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_IMM;
        state_d = op == OP_R    ? EXEC_R :
                  op == OP_I    ? EXEC_I :
                  op == OP_LW || op == OP_SW ? MEM_ADR :
                  op == OP_BR   ? BRANCH :
                  op == OP_JAL  ? JAL :
                  op == OP_JALR ? JALR_ADR :
                  op == OP_LUI  ? LUI : TRAP;
      end
      EXEC_R: begin
        ALUSrcA = SA_RS1;
        ALUOp   = ALU_RF;
        state_d = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA = SA_RS1;
        ALUSrcB = SB_IMM;
        ALUOp   = ALU_IF;
        state_d = ALU_WB;
      end
      ALU_WB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEM_ADR: begin
        ALUSrcA = SA_RS1;
        ALUSrcB = SB_IMM;
        state_d = op == OP_LW ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        adrSrc  = 1'b1;
        state_d = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        regWrite  = 1'b1;
        resultSrc = RES_MEM;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEM_WRITE: begin
        mem_req  = 1'b1;
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        retire   = mem_ready;
        state_d  = mem_ready ? FETCH : MEM_WRITE;
      end
      BRANCH: begin
        ALUSrcA = SA_RS1;
        ALUOp   = ALU_SUB;
        pcWrite = taken;
        retire  = 1'b1;
        state_d = FETCH;
      end
      JAL, JALR_JMP: begin
        pcWrite = 1'b1;
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_FOUR;
        state_d = ALU_WB;
      end
      JALR_ADR: begin
        ALUSrcA = SA_RS1;
        ALUSrcB = SB_IMM;
        state_d = JALR_JMP;
      end
      LUI: begin
        regWrite  = 1'b1;
        resultSrc = RES_IMM;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // reset must suppress every side effect, even mid-instruction
    if (!rst_n) begin
      mem_req  = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      regWrite = 1'b0;
    end
    illegal_d = illegal_q | (state_d == TRAP);
    instret_d = instret_q + CNT_W'(retire);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end
  assign illegal = illegal_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed program against a cycle-level expectation model of the controller
module tb_multicycle_controller;
  logic        clk = 1'b1;
  logic        rst_n = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  func3 = '0;
  logic        zero = 1'b0, neg = 1'b0, mem_ready = 1'b0;
  logic        mem_req, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, resultSrc;
  logic [2:0]  immSrc;
  logic [31:0] instret;
  always #5 clk = ~clk;
  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .zero(zero), .neg(neg),
    .mem_ready(mem_ready), .mem_req(mem_req), .memWrite(memWrite), .adrSrc(adrSrc),
    .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .resultSrc(resultSrc), .immSrc(immSrc),
    .illegal(illegal), .instret(instret)
  );
  localparam bit [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LW = 7'b0000011, O_SW = 7'b0100011;
  localparam bit [6:0] O_BR = 7'b1100011, O_JAL = 7'b1101111, O_JALR = 7'b1100111, O_LUI = 7'b0110111;
  localparam bit [6:0] O_BAD = 7'b1111111;
  // enable vector order: {mem_req, memWrite, irWrite, pcWrite, regWrite}
  localparam bit [4:0] E_MREQ = 5'b10000, E_MW = 5'b01000, E_IR = 5'b00100, E_PC = 5'b00010, E_RW = 5'b00001;
  typedef struct {
    bit        rst, rdy, eo;
    bit [6:0]  op;
    bit [2:0]  f3;
    bit        z, n;
    bit [4:0]  en;
    bit [8:0]  sel;
    bit [2:0]  imm;
    bit        ill;
    int unsigned cnt;
    int        pin;
  } cyc_t;
  cyc_t q[$];
  cyc_t cur;
  bit          active = 1'b0;
  int          errors = 0, checks = 0, cycle = 0;
  bit [6:0]    m_op;
  bit [2:0]    m_f3;
  bit          m_z, m_n, m_ill;
  int unsigned m_cnt;
  int          m_pin = -1;
  function automatic bit [2:0] imm_of(input bit [6:0] o);
    case (o)
      O_SW:    return 3'b001;
      O_BR:    return 3'b010;
      O_JAL:   return 3'b011;
      O_LUI:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction
  function automatic bit br_taken(input bit [2:0] f3, input bit z, input bit n);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n;
      3'd5:    return !n;
      default: return 1'b0;
    endcase
  endfunction
  task automatic put(input bit rdy, input bit [4:0] en, input bit adr, input bit [1:0] sa, sb, aop, rs);
    cyc_t c;
    c.rst = 1'b1; c.rdy = rdy; c.eo = 1'b0;
    c.op = m_op; c.f3 = m_f3; c.z = m_z; c.n = m_n;
    c.en = en; c.sel = {adr, sa, sb, aop, rs};
    c.imm = imm_of(m_op); c.ill = m_ill; c.cnt = m_cnt; c.pin = m_pin;
    m_pin = -1;
    q.push_back(c);
  endtask
  task automatic rst_cyc();
    cyc_t c;
    c = '{default: 0};
    c.rst = 1'b0; c.rdy = 1'b1; c.eo = 1'b1; c.op = m_op; c.pin = -1;
    q.push_back(c);
    m_cnt = 0;
    m_ill = 1'b0;
  endtask
  task automatic fetch_dec(input int fw);
    repeat (fw) put(1'b0, E_MREQ, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2);
    put(1'b1, E_MREQ | E_IR | E_PC, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2);
    put(1'b1, 5'b0, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0);
  endtask
  task automatic wb();
    put(1'b1, E_RW, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    m_cnt++;
  endtask
  task automatic instr(input bit [6:0] o, input bit [2:0] f3, input bit z, n, input int fw, mw);
    m_op = o; m_f3 = f3; m_z = z; m_n = n;
    fetch_dec(fw);
    case (o)
      O_R: begin put(1'b1, 5'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0); wb(); end
      O_I: begin put(1'b1, 5'b0, 1'b0, 2'd2, 2'd1, 2'd3, 2'd0); wb(); end
      O_LW: begin
        put(1'b1, 5'b0, 1'b0, 2'd2, 2'd1, 2'd0, 2'd0);
        repeat (mw) put(1'b0, E_MREQ, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        put(1'b1, E_MREQ, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        put(1'b1, E_RW, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1);
        m_cnt++;
      end
      O_SW: begin
        put(1'b1, 5'b0, 1'b0, 2'd2, 2'd1, 2'd0, 2'd0);
        repeat (mw) put(1'b0, E_MREQ | E_MW, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        put(1'b1, E_MREQ | E_MW, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        m_cnt++;
      end
      O_BR: begin
        put(1'b1, br_taken(f3, z, n) ? E_PC : 5'b0, 1'b0, 2'd2, 2'd0, 2'd1, 2'd0);
        m_cnt++;
      end
      O_JAL: begin put(1'b1, E_PC, 1'b0, 2'd1, 2'd2, 2'd0, 2'd0); wb(); end
      O_JALR: begin
        put(1'b1, 5'b0, 1'b0, 2'd2, 2'd1, 2'd0, 2'd0);
        put(1'b1, E_PC, 1'b0, 2'd1, 2'd2, 2'd0, 2'd0);
        wb();
      end
      O_LUI: begin put(1'b1, E_RW, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3); m_cnt++; end
      default: begin
        m_ill = 1'b1;
        for (int i = 0; i < 20; i++) put(i[0], 5'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      end
    endcase
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask
  always @(negedge clk) if (active) begin
    chk("enables", {27'b0, mem_req, memWrite, irWrite, pcWrite, regWrite}, {27'b0, cur.en});
    if (!cur.eo) begin
      chk("selects", {23'b0, adrSrc, ALUSrcA, ALUSrcB, ALUOp, resultSrc}, {23'b0, cur.sel});
      chk("immSrc", {29'b0, immSrc}, {29'b0, cur.imm});
      chk("illegal", {31'b0, illegal}, {31'b0, cur.ill});
      chk("instret", instret, cur.cnt);
    end
    if (cur.pin >= 0) chk("instret_literal", instret, cur.pin);
  end
  initial begin
    m_op = 7'b0; m_f3 = 3'b0; m_z = 1'b0; m_n = 1'b0; m_ill = 1'b0; m_cnt = 0;
    rst_cyc(); rst_cyc();
    instr(O_R, 3'd0, 1'b0, 1'b0, 0, 0);
    m_pin = 1;
    instr(O_I, 3'd0, 1'b0, 1'b0, 1, 0);
    instr(O_LW, 3'd2, 1'b0, 1'b0, 0, 2);
    instr(O_SW, 3'd2, 1'b0, 1'b0, 0, 1);
    instr(O_BR, 3'd0, 1'b1, 1'b0, 0, 0);
    instr(O_BR, 3'd1, 1'b1, 1'b0, 0, 0);
    instr(O_BR, 3'd4, 1'b0, 1'b1, 0, 0);
    instr(O_BR, 3'd5, 1'b0, 1'b1, 0, 0);
    instr(O_BR, 3'd2, 1'b1, 1'b0, 2, 0);
    instr(O_JAL, 3'd0, 1'b0, 1'b0, 0, 0);
    instr(O_JALR, 3'd0, 1'b0, 1'b0, 0, 0);
    instr(O_LUI, 3'd0, 1'b0, 1'b0, 0, 0);
    m_pin = 12;
    m_op = O_SW; m_f3 = 3'd2;
    fetch_dec(0);
    put(1'b1, 5'b0, 1'b0, 2'd2, 2'd1, 2'd0, 2'd0);
    put(1'b0, E_MREQ | E_MW, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    rst_cyc();
    m_pin = 0;
    instr(O_R, 3'd0, 1'b0, 1'b0, 0, 0);
    m_pin = 1;
    instr(O_BAD, 3'd0, 1'b0, 1'b0, 0, 0);
    rst_cyc();
    instr(O_LUI, 3'd0, 1'b0, 1'b0, 0, 0);
    m_pin = 1;
    put(1'b0, E_MREQ, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2);
    while (q.size() > 0) begin
      cur = q.pop_front();
      rst_n = cur.rst; mem_ready = cur.rdy; op = cur.op; func3 = cur.f3; zero = cur.z; neg = cur.n;
      active = 1'b1;
      @(posedge clk);
      #1;
      cycle++;
    end
    active = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d got=running expected=finished", cycle);
    $fatal(1, "timeout");
  end
endmodule
